inv_sqrt_nr: RTL and testbench



---
 rtl/inv_sqrt_nr.sv | 238 +++++++++++++++++++++++
 tb/tb_inv_sqrt_nr.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sqrt_nr.sv
// inv_sqrt_nr
// Fixed-point inverse square root y = 1/sqrt(x) for the feature-normalisation
// path. A seed comes from the magic-constant trick on an 18-bit pseudo-float
// {8-bit biased exponent, 10-bit mantissa}. NR_ITER Newton-Raphson passes
// then refine that seed in fixed point.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   dv_i    : operand valid, sampled only while rdy_o=1
//   sq_i    : unsigned operand x, IFRAC fractional bits
//   rdy_o   : high while idle (a new operand can be accepted)
//   dv_o    : one-cycle result-valid pulse
//   isrt_o  : unsigned result, OFRAC fractional bits (all ones on saturation/zero)
//   err_o   : zero-operand flag, meaningful while dv_o=1
//
// State       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for dv_i, rdy_o=1
// ST_NORM     | leading-one encode: exponent e, 10-bit mantissa f, zero flag
// ST_SEED     | W2 = MAGIC - ({e+127,f} >> 1)
// ST_DECODE   | y0 = 1.W2[9:0] * 2^(W2[17:10]-127), 16 fractional bits
// ST_NR_SQ    | s = y*y
// ST_NR_MUL   | t = (x*s) >> 1
// ST_NR_UPD   | y = y*(1.5 - t), clamped at 0; loop until NR_ITER passes
// ST_OUT      | load outputs, pulse dv_o, back to idle

module inv_sqrt_nr #(
   parameter int          IBIT    = 32,
   parameter int          IFRAC   = 10,
   parameter int          OBIT    = 16,
   parameter int          OFRAC   = 10,
   parameter int          NR_ITER = 1,
   parameter logic [17:0] MAGIC   = 18'd195002
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dv_i,
   input  logic [IBIT-1:0] sq_i,
   output logic            rdy_o,
   output logic            dv_o,
   output logic [OBIT-1:0] isrt_o,
   output logic            err_o
);

   // y carries YF fractional bits; s = y*y then has 2*YF and t = x*s/2 has
   // IFRAC + 2*YF. All three live in IW-bit registers.
   localparam int YF = 16;
   localparam int IW = 2 * IBIT;
   localparam int TF = IFRAC + 2 * YF;
   localparam int PW = IBIT + IW;
   localparam int PB = $clog2(IBIT);

   localparam logic [IW-1:0]       THREE_HALF = IW'(3) << (TF - 1);
   localparam logic [IW-1:0]       SAT_LIM    = IW'(1) << (OBIT - OFRAC + YF);
   localparam logic signed [9:0]   SH_BIAS    = 10'(YF - 10);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NORM,
      ST_SEED,
      ST_DECODE,
      ST_NR_SQ,
      ST_NR_MUL,
      ST_NR_UPD,
      ST_OUT
   } state_t;

   state_t          state_q, state_d;
   logic [IBIT-1:0] x_q, x_d;
   logic            zero_q, zero_d;
   logic [7:0]      e_q, e_d;
   logic [9:0]      f_q, f_d;
   logic [17:0]     w2_q, w2_d;
   logic [IW-1:0]   y_q, y_d;
   logic [IW-1:0]   s_q, s_d;
   logic [IW-1:0]   t_q, t_d;
   logic [1:0]      iter_q, iter_d;
   logic            dv_q, dv_d;
   logic [OBIT-1:0] isrt_q, isrt_d;
   logic            err_q, err_d;

   // Leading-one position of the latched operand; highest set bit wins.
   logic [PB-1:0]   lead_pos;

   always_comb begin
      lead_pos = '0;
      for (int i = 0; i < IBIT; i++) begin
         if (x_q[i]) lead_pos = PB'(i);
      end
   end

   // Shift the leading one up to the MSB; the next 10 bits are the mantissa,
   // zero-padded from below when fewer than 10 bits sit under the leading one.
   logic [IBIT-1:0] x_norm;
   assign x_norm = x_q << (PB'(IBIT - 1) - lead_pos);

   logic [17:0] w_seed;
   assign w_seed = {e_q + 8'd127, f_q};

   // Seed exponent E2 and the shift that places 1.m * 2^E2 at YF fraction bits.
   logic signed [9:0] e2;
   logic signed [9:0] sh;
   logic [IW-1:0]     mant;
   logic [IW-1:0]     y_seed;

   assign e2     = $signed({2'b00, w2_q[17:10]}) - 10'sd127;
   assign sh     = e2 + SH_BIAS;
   assign mant   = IW'({1'b1, w2_q[9:0]});
   assign y_seed = sh[9] ? (mant >> (-sh)) : (mant << sh);

   // Newton-Raphson datapath; products are formed wide and truncated.
   logic [PW-1:0]   xs_full;
   logic [IW-1:0]   u_fac;
   logic [2*IW-1:0] yu_full;

   assign xs_full = PW'(x_q) * PW'(s_q);
   assign u_fac   = (t_q > THREE_HALF) ? '0 : (THREE_HALF - t_q);
   assign yu_full = (2 * IW)'(y_q) * (2 * IW)'(u_fac);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      zero_d  = zero_q;
      e_d     = e_q;
      f_d     = f_q;
      w2_d    = w2_q;
      y_d     = y_q;
      s_d     = s_q;
      t_d     = t_q;
      iter_d  = iter_q;
      dv_d    = 1'b0;
      isrt_d  = isrt_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (dv_i) begin
               x_d     = sq_i;
               state_d = ST_NORM;
            end
         end

         ST_NORM: begin
            zero_d = (x_q == '0);
            if (x_q == '0) begin
               e_d = 8'd0;
               f_d = 10'd0;
            end else begin
               e_d = 8'(lead_pos) - 8'(IFRAC);
               f_d = 10'(x_norm >> (IBIT - 11));
            end
            state_d = ST_SEED;
         end

         ST_SEED: begin
            w2_d    = MAGIC - (w_seed >> 1);
            state_d = ST_DECODE;
         end

         ST_DECODE: begin
            y_d     = y_seed;
            iter_d  = 2'd0;
            state_d = (NR_ITER > 0) ? ST_NR_SQ : ST_OUT;
         end

         ST_NR_SQ: begin
            s_d     = y_q * y_q;
            state_d = ST_NR_MUL;
         end

         ST_NR_MUL: begin
            t_d     = IW'(xs_full >> 1);
            state_d = ST_NR_UPD;
         end

         ST_NR_UPD: begin
            y_d    = IW'(yu_full >> TF);
            iter_d = 2'(iter_q + 2'd1);
            if (iter_q == 2'(NR_ITER - 1)) state_d = ST_OUT;
            else                           state_d = ST_NR_SQ;
         end

         ST_OUT: begin
            dv_d = 1'b1;
            if (zero_q) begin
               isrt_d = '1;
               err_d  = 1'b1;
            end else begin
               err_d = 1'b0;
               if (y_q >= SAT_LIM) isrt_d = '1;
               else                isrt_d = OBIT'(y_q >> (YF - OFRAC));
            end
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         zero_q  <= 1'b0;
         e_q     <= '0;
         f_q     <= '0;
         w2_q    <= '0;
         y_q     <= '0;
         s_q     <= '0;
         t_q     <= '0;
         iter_q  <= '0;
         dv_q    <= 1'b0;
         isrt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         zero_q  <= zero_d;
         e_q     <= e_d;
         f_q     <= f_d;
         w2_q    <= w2_d;
         y_q     <= y_d;
         s_q     <= s_d;
         t_q     <= t_d;
         iter_q  <= iter_d;
         dv_q    <= dv_d;
         isrt_q  <= isrt_d;
         err_q   <= err_d;
      end
   end

   assign rdy_o  = (state_q == ST_IDLE);
   assign dv_o   = dv_q;
   assign isrt_o = isrt_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_inv_sqrt_nr.sv
// Directed bench for inv_sqrt_nr. Three instances share clock and reset:
// index 0 has NR_ITER=0, index 1 uses the defaults (NR_ITER=1), and index 2
// has NR_ITER=2. Outputs are sampled on the falling edge.

module tb_inv_sqrt_nr;

   logic        clk;
   logic        rst_n;
   logic        dv_i   [3];
   logic [31:0] sq_i   [3];
   logic        rdy_o  [3];
   logic        dv_o   [3];
   logic [15:0] isrt_o [3];
   logic        err_o  [3];

   int nvec = 0;
   int nerr = 0;

   inv_sqrt_nr #(.NR_ITER(0)) u_nr0 (
      .clk(clk), .rst_n(rst_n), .dv_i(dv_i[0]), .sq_i(sq_i[0]),
      .rdy_o(rdy_o[0]), .dv_o(dv_o[0]), .isrt_o(isrt_o[0]), .err_o(err_o[0]));

   inv_sqrt_nr u_dut (
      .clk(clk), .rst_n(rst_n), .dv_i(dv_i[1]), .sq_i(sq_i[1]),
      .rdy_o(rdy_o[1]), .dv_o(dv_o[1]), .isrt_o(isrt_o[1]), .err_o(err_o[1]));

   inv_sqrt_nr #(.NR_ITER(2)) u_nr2 (
      .clk(clk), .rst_n(rst_n), .dv_i(dv_i[2]), .sq_i(sq_i[2]),
      .rdy_o(rdy_o[2]), .dv_o(dv_o[2]), .isrt_o(isrt_o[2]), .err_o(err_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, nvec=%0d", nvec);
      $fatal(1, "bench timeout");
   end

   // Issue one operand and wait for its result. lat is the number of edges
   // from the accepting edge to the edge that raised dv_o (-1 on timeout);
   // busy_bad counts busy cycles with rdy_o high plus a dv_o cycle without it.
   task automatic run_op(input int u, input logic [31:0] x,
                         output logic [15:0] res, output logic er,
                         output int lat, output int busy_bad);
      busy_bad = 0;
      lat      = -1;
      res      = '0;
      er       = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 50 && !rdy_o[u]; i++) @(negedge clk);
      dv_i[u] = 1'b1;
      sq_i[u] = x;
      @(negedge clk);
      dv_i[u] = 1'b0;
      sq_i[u] = $urandom;
      for (int c = 1; c <= 40; c++) begin
         if (dv_o[u]) begin
            lat = c - 1;
            res = isrt_o[u];
            er  = err_o[u];
            if (!rdy_o[u]) busy_bad++;
            break;
         end
         if (rdy_o[u]) busy_bad++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int u = 0; u < 3; u++) begin
         dv_i[u] = 1'b0;
         sq_i[u] = '0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         nvec++;
         if ({rdy_o[u], dv_o[u], isrt_o[u], err_o[u]} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            nerr++;
            $display("FAIL reset_state[%0d]: got rdy=%b dv=%b isrt=%h err=%b want 1 0 0000 0",
                     u, rdy_o[u], dv_o[u], isrt_o[u], err_o[u]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [15:0] res;
      logic        er;
      int          lat, bb, d;
      run_op(1, 32'd1024, res, er, lat, bb);
      d = int'(res) - 1024;
      nvec++;
      if (d < -2 || d > 2) begin
         nerr++; $display("FAIL basic_value: got %0d want 1024+-2", res);
      end
      nvec++;
      if (lat !== 7) begin
         nerr++; $display("FAIL basic_latency: got %0d want 7", lat);
      end
      nvec++;
      if (er !== 1'b0) begin
         nerr++; $display("FAIL basic_err: got %b want 0", er);
      end
      nvec++;
      if (bb !== 0) begin
         nerr++; $display("FAIL basic_rdy_busy: got %0d bad cycles want 0", bb);
      end
   endtask

   task automatic test_values();
      logic [31:0] ops [4];
      int          exp_v [4];
      int          tol [4];
      logic [15:0] res;
      logic        er;
      int          lat, bb, d;
      ops[0] = 32'd4096;       exp_v[0] = 512;   tol[0] = 2;
      ops[1] = 32'd256;        exp_v[1] = 2048;  tol[1] = 4;
      ops[2] = 32'd1;          exp_v[2] = 32768; tol[2] = 66;
      ops[3] = 32'h8000_0000;  exp_v[3] = 0;     tol[3] = 0;
      for (int i = 0; i < 4; i++) begin
         run_op(1, ops[i], res, er, lat, bb);
         d = int'(res) - exp_v[i];
         nvec++;
         if (d < -tol[i] || d > tol[i] || er !== 1'b0 || lat !== 7) begin
            nerr++;
            $display("FAIL value[x=%0d]: got %0d err=%b lat=%0d want %0d+-%0d err=0 lat=7",
                     ops[i], res, er, lat, exp_v[i], tol[i]);
         end
      end
   endtask

   task automatic test_zero();
      logic [15:0] res;
      logic        er;
      int          lat, bb;
      run_op(1, 32'd0, res, er, lat, bb);
      nvec++;
      if (res !== 16'hFFFF || er !== 1'b1 || lat !== 7) begin
         nerr++;
         $display("FAIL zero_input: got %h err=%b lat=%0d want ffff err=1 lat=7", res, er, lat);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (isrt_o[1] !== 16'hFFFF || err_o[1] !== 1'b1 || dv_o[1] !== 1'b0) begin
         nerr++;
         $display("FAIL zero_hold: got %h err=%b dv=%b want ffff 1 0", isrt_o[1], err_o[1], dv_o[1]);
      end
   endtask

   task automatic test_nr0();
      logic [15:0] res;
      logic        er;
      int          lat, bb, d;
      run_op(0, 32'd4096, res, er, lat, bb);
      d = int'(res) - 494;
      nvec++;
      if (d < -18 || d > 18 || er !== 1'b0) begin
         nerr++; $display("FAIL nr0_value: got %0d err=%b want 494+-18 err=0", res, er);
      end
      nvec++;
      if (lat !== 4 || bb !== 0) begin
         nerr++; $display("FAIL nr0_latency: got lat=%0d busy_bad=%0d want 4 0", lat, bb);
      end
   endtask

   task automatic test_nr2();
      logic [15:0] res;
      logic        er;
      int          lat, bb, d;
      run_op(2, 32'd4096, res, er, lat, bb);
      d = int'(res) - 512;
      nvec++;
      if (d < -2 || d > 2 || er !== 1'b0) begin
         nerr++; $display("FAIL nr2_value: got %0d err=%b want 512+-2 err=0", res, er);
      end
      nvec++;
      if (lat !== 10 || bb !== 0) begin
         nerr++; $display("FAIL nr2_latency: got lat=%0d busy_bad=%0d want 10 0", lat, bb);
      end
   endtask

   // Operands spread over the whole dynamic range, checked against 1/sqrt.
   task automatic test_sweep(input int u, input int n, input real rel, input real lsb);
      logic [15:0] res;
      logic        er;
      int          lat, bb;
      logic [31:0] x;
      real         ideal, dev;
      for (int i = 0; i < n; i++) begin
         x = $urandom >> $urandom_range(0, 31);
         if (x == 32'd0) x = 32'd1;
         run_op(u, x, res, er, lat, bb);
         ideal = 1024.0 / $sqrt(real'(x) / 1024.0);
         dev   = real'(res) - ideal;
         if (dev < 0.0) dev = -dev;
         nvec++;
         if (dev > rel * ideal + lsb || er !== 1'b0 || lat < 0) begin
            nerr++;
            $display("FAIL sweep[u%0d x=%0d]: got %0d err=%b lat=%0d want %f within %f",
                     u, x, res, er, lat, ideal, rel * ideal + lsb);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops [3];
      int          exp_v [3];
      int          tol [3];
      int          acc_c [3];
      int          res_c [3];
      logic [15:0] res_v [3];
      int          acc, nres, consec, d;
      logic        prev;
      ops[0] = 32'd1024; exp_v[0] = 1024; tol[0] = 2;
      ops[1] = 32'd4096; exp_v[1] = 512;  tol[1] = 2;
      ops[2] = 32'd256;  exp_v[2] = 2048; tol[2] = 4;
      for (int i = 0; i < 3; i++) begin
         acc_c[i] = -100; res_c[i] = -200; res_v[i] = '0;
      end
      acc = 0; nres = 0; consec = 0; prev = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 60; c++) begin
         if (dv_o[1]) begin
            if (nres < 3) begin
               res_v[nres] = isrt_o[1];
               res_c[nres] = c;
            end
            nres++;
            if (prev) consec++;
         end
         prev = dv_o[1];
         if (rdy_o[1]) begin
            if (acc < 3) begin
               dv_i[1]    = 1'b1;
               sq_i[1]    = ops[acc];
               acc_c[acc] = c;
               acc++;
            end else begin
               dv_i[1] = 1'b0;
            end
         end
         @(negedge clk);
      end
      dv_i[1] = 1'b0;
      nvec++;
      if (nres !== 3 || consec !== 0) begin
         nerr++; $display("FAIL b2b_count: got %0d results consec=%0d want 3 0", nres, consec);
      end
      for (int i = 0; i < 3; i++) begin
         d = int'(res_v[i]) - exp_v[i];
         nvec++;
         if (d < -tol[i] || d > tol[i] || res_c[i] - acc_c[i] !== 8) begin
            nerr++;
            $display("FAIL b2b_result[%0d]: got %0d after %0d cycles want %0d+-%0d after 8",
                     i, res_v[i], res_c[i] - acc_c[i], exp_v[i], tol[i]);
         end
      end
      nvec++;
      if (acc_c[1] - acc_c[0] !== 8 || acc_c[2] - acc_c[1] !== 8) begin
         nerr++;
         $display("FAIL b2b_spacing: got %0d,%0d want 8,8", acc_c[1] - acc_c[0], acc_c[2] - acc_c[1]);
      end
   endtask

   task automatic test_ignore_busy();
      int          ndv, d;
      logic [15:0] res;
      logic        er;
      ndv = 0; res = '0; er = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 50 && !rdy_o[1]; i++) @(negedge clk);
      dv_i[1] = 1'b1;
      sq_i[1] = 32'd1024;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (dv_o[1]) begin
            ndv++;
            res = isrt_o[1];
            er  = err_o[1];
         end
         dv_i[1] = !rdy_o[1];
         sq_i[1] = (c % 2 == 1) ? 32'd0 : 32'd4096;
      end
      dv_i[1] = 1'b0;
      d = int'(res) - 1024;
      nvec++;
      if (ndv !== 1 || d < -2 || d > 2 || er !== 1'b0) begin
         nerr++;
         $display("FAIL ignore_busy: got %0d pulses value=%0d err=%b want 1 pulse 1024+-2 err=0",
                  ndv, res, er);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] res;
      logic        er;
      int          lat, bb, ndv, d;
      run_op(1, 32'd0, res, er, lat, bb);
      @(negedge clk);
      dv_i[1] = 1'b1;
      sq_i[1] = 32'd4096;
      @(negedge clk);
      dv_i[1] = 1'b0;
      // Four more edges put the operand in the x*s step.
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if ({rdy_o[1], dv_o[1], isrt_o[1], err_o[1]} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
         nerr++;
         $display("FAIL async_reset: got rdy=%b dv=%b isrt=%h err=%b want 1 0 0000 0",
                  rdy_o[1], dv_o[1], isrt_o[1], err_o[1]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndv = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (dv_o[1]) ndv++;
      end
      nvec++;
      if (ndv !== 0) begin
         nerr++; $display("FAIL reset_discard: got %0d dv pulses want 0", ndv);
      end
      run_op(1, 32'd1024, res, er, lat, bb);
      d = int'(res) - 1024;
      nvec++;
      if (d < -2 || d > 2 || er !== 1'b0 || lat !== 7) begin
         nerr++;
         $display("FAIL post_reset: got %0d err=%b lat=%0d want 1024+-2 err=0 lat=7", res, er, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_zero();
      test_nr0();
      test_nr2();
      test_sweep(1, 150, 0.002, 2.0);
      test_sweep(2, 50, 0.0, 2.0);
      test_back_to_back();
      test_ignore_busy();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
